// File: rtl/reg_file_wb.sv
// Writeback-stage register file: 2**ADDR_W x DATA_W registers, two combinational
// operand read ports with optional same-cycle bypass, a registered debug port and a write counter.
module reg_file_wb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [31:0]       wr_count
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic [31:0]       cnt_q;
  logic              commit;

  // x0 is never written, so a write to it neither lands nor counts
  assign commit = we && (wa != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      regs[wa] <= wd;
    end
  end

  // Bypass is gated by rst so a held reset reads the cleared array, not wd
  always_comb begin
    rd1 = regs[ra1];
    if (ra1 == '0) begin
      rd1 = '0;
    end else if (BYPASS && rst && we && (wa == ra1)) begin
      rd1 = wd;
    end
  end

  always_comb begin
    rd2 = regs[ra2];
    if (ra2 == '0) begin
      rd2 = '0;
    end else if (BYPASS && rst && we && (wa == ra2)) begin
      rd2 = wd;
    end
  end

  // Debug port sees the pre-write array: a same-cycle write shows up one cycle later
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dbg_data <= '0;
    end else begin
      dbg_data <= (dbg_addr == '0) ? '0 : regs[dbg_addr];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (commit) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign wr_count = cnt_q;

endmodule

// File: tb/tb_reg_file_wb.sv
// Self-checking bench for reg_file_wb: vector table with a debug-port scoreboard queue,
// plus hand-written sequences for bypass, counter wrap and reset corner cases.
module tb_reg_file_wb;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [4:0]  dbg;
    logic [31:0] exp_rd1;
    logic [31:0] exp_rd2;
    logic [31:0] exp_dbg;
    logic [31:0] exp_count;
  } vector_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  wa = '0;
  logic [31:0] wd = '0;
  logic [4:0]  ra1 = '0;
  logic [4:0]  ra2 = '0;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] rd1, rd2, dbg_data, wr_count;
  logic [31:0] rd1_nb, rd2_nb, dbg_data_nb, wr_count_nb;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] dbg_q [$];
  vector_t     vecs [8];

  reg_file_wb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .wr_count(wr_count)
  );

  reg_file_wb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_nb), .rd2(rd2_nb),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data_nb), .wr_count(wr_count_nb)
  );

  always #50 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drive on the falling edge, check reads mid-cycle, check registered outputs after the rising edge
  task automatic applyStimulus(input vector_t v);
    @(negedge clk);
    we = v.we; wa = v.wa; wd = v.wd; ra1 = v.ra1; ra2 = v.ra2; dbg_addr = v.dbg;
    dbg_q.push_back(v.exp_dbg);
    #1;
    checkOutput("rd1", rd1, v.exp_rd1);
    checkOutput("rd2", rd2, v.exp_rd2);
    @(posedge clk);
    #1;
    checkOutput("dbg_data", dbg_data, dbg_q.pop_front());
    checkOutput("wr_count", wr_count, v.exp_count);
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd0,  32'hDEADBEEF, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'd0};
    vecs[1] = '{1'b1, 5'd5,  32'h12345678, 5'd0,  5'd3,  5'd5,  32'h0,        32'h0,        32'h0,        32'd1};
    vecs[2] = '{1'b0, 5'd5,  32'h00000000, 5'd5,  5'd5,  5'd5,  32'h12345678, 32'h12345678, 32'h12345678, 32'd1};
    vecs[3] = '{1'b1, 5'd9,  32'hCAFEF00D, 5'd9,  5'd5,  5'd9,  32'hCAFEF00D, 32'h12345678, 32'h0,        32'd2};
    vecs[4] = '{1'b1, 5'd9,  32'h0BADC0DE, 5'd9,  5'd9,  5'd9,  32'h0BADC0DE, 32'h0BADC0DE, 32'hCAFEF00D, 32'd3};
    vecs[5] = '{1'b0, 5'd9,  32'hFFFFFFFF, 5'd9,  5'd0,  5'd9,  32'h0BADC0DE, 32'h0,        32'h0BADC0DE, 32'd3};
    vecs[6] = '{1'b1, 5'd31, 32'h80000001, 5'd31, 5'd30, 5'd0,  32'h80000001, 32'h0,        32'h0,        32'd4};
    vecs[7] = '{1'b0, 5'd0,  32'h00000000, 5'd31, 5'd31, 5'd31, 32'h80000001, 32'h80000001, 32'h80000001, 32'd4};

    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("initial reset wr_count", wr_count, 32'd0);
    checkOutput("initial reset dbg_data", dbg_data, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
    end

    // Bypass versus no-bypass instance on the same write to x7
    @(negedge clk);
    we = 1'b1; wa = 5'd7; wd = 32'hA5A5A5A5; ra1 = 5'd0; ra2 = 5'd7; dbg_addr = 5'd7;
    #1;
    checkOutput("bypass rd2", rd2, 32'hA5A5A5A5);
    checkOutput("no-bypass rd2 before edge", rd2_nb, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("no-bypass rd2 after edge", rd2_nb, 32'hA5A5A5A5);
    checkOutput("dbg_data old x7", dbg_data, 32'h0);
    checkOutput("wr_count after x7", wr_count, 32'd5);
    @(negedge clk);
    wd = 32'h5A5A5A5A;
    #1;
    checkOutput("bypass rd2 rewrite", rd2, 32'h5A5A5A5A);
    checkOutput("no-bypass rd2 old x7", rd2_nb, 32'hA5A5A5A5);
    @(posedge clk);
    #1;
    checkOutput("no-bypass rd2 new x7", rd2_nb, 32'h5A5A5A5A);
    checkOutput("dbg_data x7 first value", dbg_data, 32'hA5A5A5A5);
    checkOutput("wr_count after rewrite", wr_count, 32'd6);

    // Counter wrap from a preloaded value
    @(negedge clk);
    we = 1'b0;
    force dut.cnt_q = 32'hFFFFFFFE;
    #1 release dut.cnt_q;
    #1 checkOutput("wr_count preload", wr_count, 32'hFFFFFFFE);
    applyStimulus('{1'b1, 5'd1, 32'h00000011, 5'd1, 5'd7, 5'd1, 32'h00000011, 32'h5A5A5A5A, 32'h0,        32'hFFFFFFFF});
    applyStimulus('{1'b1, 5'd1, 32'h00000022, 5'd1, 5'd7, 5'd1, 32'h00000022, 32'h5A5A5A5A, 32'h00000011, 32'h00000000});
    applyStimulus('{1'b1, 5'd1, 32'h00000033, 5'd1, 5'd7, 5'd1, 32'h00000033, 32'h5A5A5A5A, 32'h00000022, 32'h00000001});

    // Held reset with live writes: every address reads zero, bypass suppressed
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      rst = 1'b0;
      dbg_addr = 5'(c + 1);
      for (int i = 0; i < 32; i++) begin
        we = 1'b1; wa = 5'(i); wd = $urandom; ra1 = 5'(i); ra2 = 5'(31 - i);
        #1;
        checkOutput("reset rd1", rd1, 32'h0);
        checkOutput("reset rd2", rd2, 32'h0);
      end
      checkOutput("reset dbg_data", dbg_data, 32'h0);
      checkOutput("reset wr_count", wr_count, 32'h0);
    end
    @(negedge clk);
    we = 1'b0; rst = 1'b1; ra1 = 5'd5; ra2 = 5'd9; dbg_addr = 5'd31;
    #1;
    checkOutput("post-reset rd1 x5", rd1, 32'h0);
    checkOutput("post-reset rd2 x9", rd2, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("post-reset dbg_data x31", dbg_data, 32'h0);
    checkOutput("post-reset wr_count", wr_count, 32'h0);

    // Reset asserted just before the edge of a write cycle loses the write
    @(negedge clk);
    we = 1'b1; wa = 5'd3; wd = 32'h1; ra1 = 5'd3; ra2 = 5'd0; dbg_addr = 5'd3;
    #1;
    checkOutput("mid-write bypass rd1", rd1, 32'h1);
    #47 rst = 1'b0;
    #1 checkOutput("mid-write reset rd1", rd1, 32'h0);
    @(posedge clk);
    #1;
    we = 1'b0; rst = 1'b1;
    #1;
    checkOutput("mid-write x3", rd1, 32'h0);
    checkOutput("mid-write wr_count", wr_count, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("mid-write dbg x3", dbg_data, 32'h0);
    checkOutput("mid-write wr_count later", wr_count, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
